bk_adder_pipe: RTL and testbench
================================

// Module: bk_adder_pipe
// PURPOSE
//  Parametrised, pipelined Brent-Kung adder/subtractor; generation-2 datapath adder for wide operands.
//  Accepts one operation per cycle over a valid/ready input port and delivers sum plus flags over a
//  valid/ready output port with full backpressure. Sits between operand-fetch and result write-back.
// PARAMETERS
//  WIDTH    32  operand width; power of two, 4..128 (elaboration error otherwise)
//  MID_REG  1   1 = register between up-sweep and down-sweep of prefix tree; 0 = none
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat present
//  in_ready   out  1      block can accept beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (ADD only)
//  sub        in   1      0 = A+B+cin; 1 = A-B (A+~B+1, cin ignored)
//  out_valid  out  1      result beat present
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry-out of MSB (SUB: 1 = no borrow)
//  ovf        out  1      signed overflow: sign(A)==sign(B')!=sign(sum), B' = effective B
//  zero       out  1      sum == 0
// BEHAVIOUR
//  - One clock, reset synchronous active-high; polarity/synchronicity fixed.
//  - Reset: all stage valids 0 -> out_valid=0; sum/cout/ovf/zero=0; in_ready=1 first cycle after rst.
//  - Stages: S0 input reg (A, B'=b^{WIDTH{sub}}, c0=sub?1:cin, bitwise g/p);
//    S1 (MID_REG=1 only) up-sweep group g/p, log2(WIDTH) levels;
//    S2 down-sweep, carries, sum=p^c, flags -> output reg.
//  - Latency in_valid&in_ready -> out_valid: 2+MID_REG cycles when unstalled; throughput 1/cycle.
//  - Per-stage valid v[k]; stage k loads when !v[k] | advance[k+1]; last stage advances on out_ready.
//    in_ready = !v[0] | advance[1]; no combinational path in_valid->in_ready.
//  - Stall: out_valid & !out_ready holds sum/flags stable; upstream fills bubbles, then in_ready=0.
//  - Results in issue order; no drop, no duplication; capacity 2+MID_REG beats.
//  - Pipeline registers without valid hold data (no clear), except output flags reset to 0.
//  - rst mid-operation: all in-flight beats discarded; no out_valid in cycle after rst.
//  - a/b/cin/sub sampled only on accepted cycles; ignored otherwise.
//  - Width rules: internal sum is WIDTH+1 bits; cout = bit WIDTH; no saturation, wrap modulo 2^WIDTH.
//  - Simultaneous accept and emit in same cycle allowed at every occupancy, including full.
// STRUCTURE
//  - Package bk_pkg: localparam fn bk_levels(w)=log2(w); typedef gp_t {g,p}; op enum OP_ADD=0, OP_SUB=1.
//  - Sub-module bk_prefix_tree #(WIDTH, SPLIT): combinational Brent-Kung network, exposes up-sweep
//    group g/p vector (for MID_REG cut) and final prefix carries c[WIDTH:1] from c0.
//  - Top holds handshake/valid chain, input inversion, flag logic, and pipeline regs only.
// TESTING
//  - ADD carry ripple: A=FFFF_FFFF, B=0, cin=1 -> sum=0, cout=1, zero=1, ovf=0, 2+MID_REG cycles later.
//  - SUB overflow: A=8000_0000, B=1, sub=1 -> sum=7FFF_FFFF, cout=1, ovf=1; A=0,B=1 -> FFFF_FFFF,
//    cout=0, ovf=0.
//  - Throughput: 100 back-to-back random beats, out_ready=1 -> in_ready stays 1; results in order,
//    match A+B+cin reference model.
//  - Backpressure: out_ready=0 for 10 cycles -> sum stable, in_ready drops after 2+MID_REG accepts;
//    release -> all beats in order, none lost.
//  - Reset mid-flight: 3 beats in, rst 1 cycle -> out_valid=0, in_ready=1 next cycle; no stale beat.
//  - Param sweep WIDTH=4/16/64/128 x MID_REG=0/1: exhaustive at W=4 (incl. sub/cin), 10k random others.

Source files
------------

// File: rtl/bk_pkg.sv
// Shared types and elaboration helpers for the Brent-Kung adder pipeline.
//   gp_t        : per-bit generate/propagate pair
//   op_e        : operation select (OP_ADD = A+B+cin, OP_SUB = A-B)
//   bk_levels   : number of prefix-tree levels, log2(w)
//   bk_width_ok : legal operand width (power of two, 4..128)
package bk_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int unsigned bk_levels(input int unsigned w);
    int unsigned l;
    l = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) < w) l = i + 1;
    end
    return l;
  endfunction

  function automatic bit bk_width_ok(input int unsigned w);
    return (w >= 4) && (w <= 128) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/bk_prefix_tree.sv
// Combinational Brent-Kung carry network.
//   g_i/p_i/c0_i     : bitwise generate/propagate and carry-in (up-sweep inputs)
//   up_g_o/up_p_o    : group g/p after the up-sweep (cut point for an optional register)
//   dn_g_i/dn_p_i    : up-sweep vector fed back in when SPLIT=1 (ignored when SPLIT=0)
//   c_o[WIDTH:1]     : carry into bit i (c_o[WIDTH] is the carry-out)
module bk_prefix_tree
  import bk_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter bit          SPLIT = 1'b1
) (
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] p_i,
  input  logic             c0_i,
  output logic [WIDTH-1:0] up_g_o,
  output logic [WIDTH-1:0] up_p_o,
  input  logic [WIDTH-1:0] dn_g_i,
  input  logic [WIDTH-1:0] dn_p_i,
  output logic [WIDTH:1]   c_o
);

  localparam int unsigned LEVELS = bk_levels(WIDTH);

  // Up-sweep. c0 is folded into bit 0 so every group G[i:0] is directly carry c[i+1].
  for (genvar l = 0; l <= LEVELS; l++) begin : g_up
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    if (l == 0) begin : g_base
      assign g = {g_i[WIDTH-1:1], g_i[0] | (p_i[0] & c0_i)};
      assign p = p_i;
    end else begin : g_lvl
      localparam int unsigned D = 1 << (l - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i + 1) % (2 * D)) == 0) begin : g_op
          assign g[i] = g_up[l-1].g[i] | (g_up[l-1].p[i] & g_up[l-1].g[i-D]);
          assign p[i] = g_up[l-1].p[i] & g_up[l-1].p[i-D];
        end else begin : g_pass
          assign g[i] = g_up[l-1].g[i];
          assign p[i] = g_up[l-1].p[i];
        end
      end
    end
  end

  assign up_g_o = g_up[LEVELS].g;
  assign up_p_o = g_up[LEVELS].p;

  // Down-sweep source: registered copy across the cut, or the live up-sweep.
  logic [WIDTH-1:0] dg0;
  logic [WIDTH-1:0] dp;
  if (SPLIT) begin : g_split
    assign dg0 = dn_g_i;
    assign dp  = dn_p_i;
  end else begin : g_comb
    logic unused_dn;
    assign unused_dn = ^{dn_g_i, dn_p_i};
    assign dg0 = up_g_o;
    assign dp  = up_p_o;
  end

  // Each position is updated at most once in the down-sweep, so group P never changes.
  logic unused_dp;
  assign unused_dp = ^dp;

  for (genvar k = 0; k < LEVELS; k++) begin : g_dn
    logic [WIDTH-1:0] g;
    if (k == 0) begin : g_base
      assign g = dg0;
    end else begin : g_lvl
      localparam int unsigned D = 1 << (LEVELS - 1 - k);
      for (genvar j = 0; j < WIDTH; j++) begin : g_bit
        if ((((j + 1) % (2 * D)) == D) && ((j + 1) > (2 * D))) begin : g_op
          assign g[j] = g_dn[k-1].g[j] | (dp[j] & g_dn[k-1].g[j-D]);
        end else begin : g_pass
          assign g[j] = g_dn[k-1].g[j];
        end
      end
    end
  end

  assign c_o = g_dn[LEVELS-1].g;

endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready on both sides.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake (a, b, cin, sub)
//   out_valid/out_ready   : result handshake (sum, cout, ovf, zero)
//   sub=1 computes a + ~b + 1 (cin ignored); cout=1 means no borrow.
// Latency 2+MID_REG cycles, one beat per cycle, capacity 2+MID_REG beats.
module bk_adder_pipe
  import bk_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter bit          MID_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  if (!bk_width_ok(WIDTH)) begin : g_bad_width
    $error("bk_adder_pipe: WIDTH must be a power of two in 4..128");
  end

  // Operand conditioning for S0.
  op_e              op_c;
  logic [WIDTH-1:0] bp_c;
  assign op_c = op_e'(sub);
  assign bp_c = (op_c == OP_SUB) ? ~b : b;

  // Handshake chain: each stage loads when empty or when its contents move on.
  logic out_free_c;
  logic s1_ready_c;
  logic acc_c;
  logic vo_q;
  logic v0_q, v0_d;
  assign out_free_c = !vo_q || out_ready;
  assign in_ready   = !v0_q || s1_ready_c;
  assign acc_c      = in_valid && in_ready;

  // S0: bitwise g/p, carry-in and A sign (B' sign is recovered as p^a).
  logic [WIDTH-1:0] g0_q, g0_d, p0_q, p0_d;
  logic             c0_q, c0_d, am0_q, am0_d;

  always_comb begin
    v0_d  = v0_q;
    g0_d  = g0_q;
    p0_d  = p0_q;
    c0_d  = c0_q;
    am0_d = am0_q;
    if (in_ready) v0_d = in_valid;
    if (acc_c) begin
      g0_d  = a & bp_c;
      p0_d  = a ^ bp_c;
      c0_d  = (op_c == OP_SUB) ? 1'b1 : cin;
      am0_d = a[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) v0_q <= 1'b0;
    else     v0_q <= v0_d;
  end

  always_ff @(posedge clk) begin
    g0_q  <= g0_d;
    p0_q  <= p0_d;
    c0_q  <= c0_d;
    am0_q <= am0_d;
  end

  // Prefix tree; the up-sweep/down-sweep cut is registered only when MID_REG=1.
  logic [WIDTH-1:0] up_g_c, up_p_c, dn_g_c, dn_p_c;
  logic [WIDTH:1]   carry_c;

  bk_prefix_tree #(
    .WIDTH (WIDTH),
    .SPLIT (MID_REG)
  ) u_tree (
    .g_i    (g0_q),
    .p_i    (p0_q),
    .c0_i   (c0_q),
    .up_g_o (up_g_c),
    .up_p_o (up_p_c),
    .dn_g_i (dn_g_c),
    .dn_p_i (dn_p_c),
    .c_o    (carry_c)
  );

  // Inputs to the final stage, from S1 or straight from S0.
  logic             s2_v_c, s2_c0_c, s2_am_c;
  logic [WIDTH-1:0] s2_p_c;

  if (MID_REG) begin : g_mid
    logic             v1_q, v1_d;
    logic [WIDTH-1:0] ug1_q, ug1_d, up1_q, up1_d, p1_q, p1_d;
    logic             c01_q, c01_d, am1_q, am1_d;

    assign s1_ready_c = !v1_q || out_free_c;

    always_comb begin
      v1_d  = v1_q;
      ug1_d = ug1_q;
      up1_d = up1_q;
      p1_d  = p1_q;
      c01_d = c01_q;
      am1_d = am1_q;
      if (s1_ready_c) begin
        v1_d = v0_q;
        if (v0_q) begin
          ug1_d = up_g_c;
          up1_d = up_p_c;
          p1_d  = p0_q;
          c01_d = c0_q;
          am1_d = am0_q;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) v1_q <= 1'b0;
      else     v1_q <= v1_d;
    end

    always_ff @(posedge clk) begin
      ug1_q <= ug1_d;
      up1_q <= up1_d;
      p1_q  <= p1_d;
      c01_q <= c01_d;
      am1_q <= am1_d;
    end

    assign dn_g_c  = ug1_q;
    assign dn_p_c  = up1_q;
    assign s2_v_c  = v1_q;
    assign s2_p_c  = p1_q;
    assign s2_c0_c = c01_q;
    assign s2_am_c = am1_q;
  end else begin : g_nomid
    logic unused_up;
    assign unused_up  = ^{up_g_c, up_p_c};
    assign s1_ready_c = out_free_c;
    assign dn_g_c     = '0;
    assign dn_p_c     = '0;
    assign s2_v_c     = v0_q;
    assign s2_p_c     = p0_q;
    assign s2_c0_c    = c0_q;
    assign s2_am_c    = am0_q;
  end

  // Final stage: sum and flags.
  logic [WIDTH-1:0] sum_c;
  logic             ovf_c;
  assign sum_c = s2_p_c ^ {carry_c[WIDTH-1:1], s2_c0_c};
  // Same-sign operands (A and B' = p^A) producing a different-sign result.
  assign ovf_c = (s2_am_c == (s2_p_c[WIDTH-1] ^ s2_am_c)) && (sum_c[WIDTH-1] != s2_am_c);

  logic             vo_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  always_comb begin
    vo_d   = vo_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (out_free_c) begin
      vo_d = s2_v_c;
      if (s2_v_c) begin
        sum_d  = sum_c;
        cout_d = carry_c[WIDTH];
        ovf_d  = ovf_c;
        zero_d = ~|sum_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vo_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      vo_q   <= vo_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = vo_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Self-checking bench: 32-bit pipe with mid register, plus an exhaustive 4-bit pipe without.
module tb_bk_adder_pipe;

  logic        clk, rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [31:0] a, b, sum;
  logic        in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, cout4, ovf4, zero4;
  logic [3:0]  a4, b4, sum4;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          mon_en = 1'b0;
  logic [34:0] q[$];
  logic [34:0] q4[$];
  logic        hold_prev = 1'b0;
  logic [34:0] hold_val;

  bk_adder_pipe #(.WIDTH(32), .MID_REG(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero));

  bk_adder_pipe #(.WIDTH(4), .MID_REG(1'b0)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .cin(cin4), .sub(sub4), .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4),
    .cout(cout4), .ovf(ovf4), .zero(zero4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic. Returns {zero, ovf, cout, sum zero-extended to 32}.
  function automatic logic [34:0] model(input int w, input longint unsigned ua, input longint unsigned ub,
                                        input logic ci, input logic su);
    longint unsigned full, s;
    longint          sa, sb, sr, lim;
    logic            co, ov;
    full = 64'd1 << w;
    // SUB: A - B + 2^w, so the bit above the sum is 1 exactly when there is no borrow.
    if (su) s = ua + full - ub;
    else    s = ua + ub + 64'(ci);
    co  = ((s >> w) & 64'd1) != 64'd0;
    s   = s & (full - 64'd1);
    lim = longint'(64'd1 << (w - 1));
    sa  = (ua >= 64'(lim)) ? longint'(ua) - longint'(full) : longint'(ua);
    sb  = (ub >= 64'(lim)) ? longint'(ub) - longint'(full) : longint'(ub);
    sr  = su ? (sa - sb) : (sa + sb + longint'(ci));
    ov  = (sr >= lim) || (sr < -lim);
    return {(s == 64'd0), ov, co, 32'(s)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: push on accept, compare on emit, verify hold while stalled.
  always @(negedge clk) begin : mon
    logic [34:0] act, act4;
    act  = {zero, ovf, cout, sum};
    act4 = {zero4, ovf4, cout4, 28'd0, sum4};
    if (mon_en) begin
      if (rst) begin
        q.delete();
        q4.delete();
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) chk("stall_hold", 64'({out_valid, act}), 64'({1'b1, hold_val}));
        hold_prev = out_valid && !out_ready;
        hold_val  = act;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL result: got beat %h, expected no beat", act);
          end else chk("result", 64'(act), 64'(q.pop_front()));
        end
        if (in_valid && in_ready) q.push_back(model(32, 64'(a), 64'(b), cin, sub));
        if (out_valid4 && out_ready4) begin
          if (q4.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL result4: got beat %h, expected no beat", act4);
          end else chk("result4", 64'(act4), 64'(q4.pop_front()));
        end
        if (in_valid4 && in_ready4) q4.push_back(model(4, 64'(a4), 64'(b4), cin4, sub4));
      end
    end
  end

  // One beat on an empty pipe; checks latency and hand-computed result.
  task automatic lit(input string nm, input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                     input logic ts, input logic [31:0] es, input logic ec, input logic eo, input logic ez);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk({nm, "_latency"}, 64'(lat), 64'd3);
    chk({nm, "_value"}, 64'({zero, ovf, cout, sum}), 64'({ez, eo, ec, es}));
  endtask

  // mode 0: always ready, in_ready must stay 1; mode 1: 10-cycle stall then release; mode 2: random ready.
  task automatic drive_beats(input int n, input int mode);
    int   sent, cyc, stall_acc;
    logic acc, last_ir;
    sent = 0; cyc = 0; stall_acc = 0; last_ir = 1'b1;
    out_ready = (mode == 1) ? 1'b0 : 1'b1;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    while (sent < n && cyc < 5000) begin
      @(negedge clk);
      acc = in_ready;
      if (mode == 0) chk("thru_in_ready", 64'(in_ready), 64'd1);
      if (mode == 1 && cyc < 10) begin
        if (acc) stall_acc++;
        last_ir = in_ready;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      end
      if (mode == 1 && cyc == 10) begin
        chk("bp_accepts", 64'(stall_acc), 64'd3);
        chk("bp_in_ready", 64'(last_ir), 64'd0);
        out_ready = 1'b1;
      end
      if (mode == 2) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    chk("drive_sent", 64'(sent), 64'(n));
  endtask

  task automatic wait_drain;
    int k;
    k = 0;
    out_ready = 1'b1;
    out_ready4 = 1'b1;
    while ((q.size() != 0 || q4.size() != 0) && k < 100) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("drain", 64'(q.size() + q4.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; out_ready4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outputs", 64'({sum, cout, ovf, zero}), 64'd0);
    chk("rst_out_valid4", 64'(out_valid4), 64'd0);

    lit("add_ripple", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    lit("sub_ovf",    32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    lit("sub_borrow", 32'h0000_0000, 32'h1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    lit("add_ovf",    32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    lit("add_mixed",  32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0);
    lit("sub_zero",   32'h0000_0005, 32'h5, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    wait_drain();

    drive_beats(100, 0);
    wait_drain();
    drive_beats(8, 1);
    wait_drain();
    drive_beats(200, 2);
    wait_drain();

    // Reset with three beats in flight and the output stalled.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rstmid_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("rstmid_no_stale", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;

    // Exhaustive 4-bit sweep with random backpressure.
    for (int i = 0; i < 1024; i++) begin
      logic acc;
      int   tries;
      a4 = 4'(i); b4 = 4'(i >> 4); cin4 = 1'(i >> 8); sub4 = 1'(i >> 9);
      in_valid4 = 1'b1;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 50) begin
        @(negedge clk);
        acc = in_ready4;
        @(posedge clk); #1;
        out_ready4 = ($urandom_range(0, 3) != 0);
        tries++;
      end
      if (!acc) chk("w4_accept", 64'(acc), 64'd1);
    end
    in_valid4 = 1'b0;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
